// File: rtl/spi_pkg.sv
// Shared encodings for the SPI flash sequencer: chip-select channels, transfer
// modes, control-port register selects and CNT_HI byte layout.
package spi_pkg;

    typedef enum logic [1:0] {
        CS_NONE  = 2'd0,
        CS_TF    = 2'd1,
        CS_FLASH = 2'd2,
        CS_MCU   = 2'd3
    } channel_cs_e;

    typedef enum logic [1:0] {
        MODE_WRITE     = 2'd0,
        MODE_READ      = 2'd1,
        MODE_EXCHANGE  = 2'd2,
        MODE_WAIT_READ = 2'd3
    } transfer_mode_e;

    typedef enum logic [1:0] {
        WSEL_TXBUF  = 2'd0,
        WSEL_CNT_LO = 2'd1,
        WSEL_CNT_HI = 2'd2,
        WSEL_CNT2   = 2'd3
    } wr_sel_e;

    localparam int CNT_HI_START_BIT = 7;
    localparam int CNT_HI_BUF_BIT   = 6;
    localparam int CNT_HI_MODE_LSB  = 4;
    localparam int CNT_HI_LEN_LSB   = 0;

    typedef enum logic [4:0] {
        ST_IDLE, ST_SEL, ST_TX0, ST_TX1, ST_TX2, ST_TX3, ST_CLO, ST_CHI,
        ST_HOLD, ST_WAIT, ST_DLO, ST_DHI, ST_DHOLD, ST_DWAIT,
        ST_ABRT, ST_AWAIT, ST_DESEL, ST_DONE
    } seq_state_e;

    function automatic logic [7:0] cnt_hi_byte(input logic start, input logic bsel,
                                               input transfer_mode_e mode,
                                               input logic [1:0] len_hi);
        logic [7:0] b;
        b = 8'h00;
        b[CNT_HI_START_BIT]          = start;
        b[CNT_HI_BUF_BIT]            = bsel;
        b[CNT_HI_MODE_LSB +: 2]      = mode;
        b[CNT_HI_LEN_LSB +: 2]       = len_hi;
        return b;
    endfunction

    function automatic logic [7:0] cnt2_byte(input channel_cs_e ch);
        return {5'b00000, ch, 1'b0};
    endfunction

endpackage

// File: rtl/spi_wait_timer.sv
// Saturating 16-bit cycle counter, cleared on each sequencer state change;
// expired_o flags that the current state has lasted limit_i cycles.
module spi_wait_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic [15:0] limit_i,
    output logic [15:0] count_o,
    output logic        expired_o
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // count_q is the number of finished cycles in the state; +1 includes the current one
    assign expired_o = ({1'b0, count_q} + 17'd1) >= {1'b0, limit_i};

endmodule

// File: rtl/spi_flash_seq.sv
// Turns one read request into the SPI engine control-port write sequence:
// select, TX fill, command transfer, data transfer, deselect, with abort/timeout.
//
// state  | meaning
// IDLE   | ready for a request
// SEL    | CNT2 write: assert chip select
// TX0-3  | TXBUF[0..3] = cmd, addr bytes MSB first
// CLO/CHI| command transfer count and start
// HOLD   | ignore busy for StartLatency cycles
// WAIT   | wait for command transfer to finish
// DLO/DHI| data transfer count and start
// DHOLD  | ignore busy for StartLatency cycles
// DWAIT  | wait for data transfer to finish
// ABRT   | CNT_HI = 0 to stop the engine
// AWAIT  | latency then busy low after engine abort
// DESEL  | CNT2 = 0
// DONE   | completion pulse
module spi_flash_seq
    import spi_pkg::*;
#(
    parameter int unsigned StartLatency  = 4,
    parameter int unsigned TimeoutCycles = 65535
) (
    input  logic        transfer_clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_channel_i,
    input  logic [7:0]  req_cmd_i,
    input  logic [23:0] req_addr_i,
    input  logic [9:0]  req_len_i,
    input  logic        req_buf_i,
    input  logic        abort_i,
    output logic        done_valid_o,
    output logic        done_aborted_o,
    output logic        spi_wr_en_o,
    output logic [1:0]  spi_wr_sel_o,
    output logic [9:0]  spi_wr_addr_o,
    output logic [7:0]  spi_wr_data_o,
    input  logic        spi_busy_i
);

    localparam logic [15:0] HOLD_LIMIT    = 16'(StartLatency);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TimeoutCycles);

    seq_state_e  state_q, state_d;
    channel_cs_e ch_q, ch_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] addr_q, addr_d;
    logic [9:0]  len_q, len_d;
    logic        bsel_q, bsel_d;
    logic        aborted_q, aborted_d;

    logic        ready_q, ready_d;
    logic        done_valid_q, done_valid_d;
    logic        done_aborted_q, done_aborted_d;
    logic        wr_en_q, wr_en_d;
    wr_sel_e     wr_sel_q, wr_sel_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic [15:0] wait_count;
    logic        hold_done;
    logic        timeout_hit;
    logic        abort_req;
    logic        early_phase;

    spi_wait_timer u_timer (
        .clk_i      (transfer_clk_i),
        .rst_i      (reset_i),
        .load_i     (state_d != state_q),
        .load_val_i (16'd0),
        .limit_i    (HOLD_LIMIT),
        .count_o    (wait_count),
        .expired_o  (hold_done)
    );

    assign timeout_hit = ({1'b0, wait_count} + 17'd1) >= {1'b0, TIMEOUT_LIMIT};
    assign early_phase = state_q inside {ST_SEL, ST_TX0, ST_TX1, ST_TX2, ST_TX3, ST_CLO};

    // ABRT/AWAIT are already unwinding, so a further abort there changes nothing
    assign abort_req = (state_q inside {ST_SEL, ST_TX0, ST_TX1, ST_TX2, ST_TX3, ST_CLO,
                                        ST_CHI, ST_HOLD, ST_WAIT, ST_DLO, ST_DHI,
                                        ST_DHOLD, ST_DWAIT})
                       && (abort_i || ((state_q inside {ST_HOLD, ST_WAIT, ST_DHOLD, ST_DWAIT})
                                       && timeout_hit));

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        len_d     = len_q;
        bsel_d    = bsel_q;
        aborted_d = aborted_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    ch_d      = channel_cs_e'(req_channel_i);
                    cmd_d     = req_cmd_i;
                    addr_d    = req_addr_i;
                    len_d     = req_len_i;
                    bsel_d    = req_buf_i;
                    aborted_d = 1'b0;
                    state_d   = ST_SEL;
                end
            end
            ST_SEL:   state_d = ST_TX0;
            ST_TX0:   state_d = ST_TX1;
            ST_TX1:   state_d = ST_TX2;
            ST_TX2:   state_d = ST_TX3;
            ST_TX3:   state_d = ST_CLO;
            ST_CLO:   state_d = ST_CHI;
            ST_CHI:   state_d = ST_HOLD;
            ST_HOLD:  if (hold_done) state_d = ST_WAIT;
            ST_WAIT:  if (!spi_busy_i) state_d = ST_DLO;
            ST_DLO:   state_d = ST_DHI;
            ST_DHI:   state_d = ST_DHOLD;
            ST_DHOLD: if (hold_done) state_d = ST_DWAIT;
            ST_DWAIT: if (!spi_busy_i) state_d = ST_DESEL;
            ST_ABRT:  state_d = ST_AWAIT;
            ST_AWAIT: if (hold_done && !spi_busy_i) state_d = ST_DESEL;
            ST_DESEL: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Nothing has been started before CHI, so there is no engine transfer to stop
        if (abort_req) begin
            aborted_d = 1'b1;
            state_d   = early_phase ? ST_DESEL : ST_ABRT;
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_sel_d  = WSEL_TXBUF;
        wr_addr_d = '0;
        wr_data_d = '0;
        case (state_d)
            ST_SEL:   begin wr_en_d = 1'b1; wr_sel_d = WSEL_CNT2;   wr_data_d = cnt2_byte(ch_d); end
            ST_TX0:   begin wr_en_d = 1'b1; wr_addr_d = 10'd0; wr_data_d = cmd_d; end
            ST_TX1:   begin wr_en_d = 1'b1; wr_addr_d = 10'd1; wr_data_d = addr_d[23:16]; end
            ST_TX2:   begin wr_en_d = 1'b1; wr_addr_d = 10'd2; wr_data_d = addr_d[15:8]; end
            ST_TX3:   begin wr_en_d = 1'b1; wr_addr_d = 10'd3; wr_data_d = addr_d[7:0]; end
            ST_CLO:   begin wr_en_d = 1'b1; wr_sel_d = WSEL_CNT_LO; wr_data_d = 8'h03; end
            ST_CHI:   begin
                wr_en_d   = 1'b1;
                wr_sel_d  = WSEL_CNT_HI;
                wr_data_d = cnt_hi_byte(1'b1, bsel_d, MODE_WRITE, 2'b00);
            end
            ST_DLO:   begin wr_en_d = 1'b1; wr_sel_d = WSEL_CNT_LO; wr_data_d = len_d[7:0]; end
            ST_DHI:   begin
                wr_en_d   = 1'b1;
                wr_sel_d  = WSEL_CNT_HI;
                wr_data_d = cnt_hi_byte(1'b1, bsel_d, MODE_READ, len_d[9:8]);
            end
            ST_ABRT:  begin wr_en_d = 1'b1; wr_sel_d = WSEL_CNT_HI; wr_data_d = 8'h00; end
            ST_DESEL: begin wr_en_d = 1'b1; wr_sel_d = WSEL_CNT2;   wr_data_d = 8'h00; end
            default:  ;
        endcase
        ready_d        = (state_d == ST_IDLE);
        done_valid_d   = (state_d == ST_DONE);
        done_aborted_d = (state_d == ST_DONE) && aborted_d;
    end

    always_ff @(posedge transfer_clk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            ch_q           <= CS_NONE;
            cmd_q          <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            bsel_q         <= 1'b0;
            aborted_q      <= 1'b0;
            ready_q        <= 1'b1;
            done_valid_q   <= 1'b0;
            done_aborted_q <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_sel_q       <= WSEL_TXBUF;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            cmd_q          <= cmd_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            bsel_q         <= bsel_d;
            aborted_q      <= aborted_d;
            ready_q        <= ready_d;
            done_valid_q   <= done_valid_d;
            done_aborted_q <= done_aborted_d;
            wr_en_q        <= wr_en_d;
            wr_sel_q       <= wr_sel_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign done_valid_o   = done_valid_q;
    assign done_aborted_o = done_aborted_q;
    assign spi_wr_en_o    = wr_en_q;
    assign spi_wr_sel_o   = wr_sel_q;
    assign spi_wr_addr_o  = wr_addr_q;
    assign spi_wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Directed bench for spi_flash_seq: table of normal reads plus abort, timeout,
// reset and back-to-back sequences, checked against hand-computed write lists.
module tb_spi_flash_seq;

    localparam int START_LAT = 4;
    localparam int TIMEOUT   = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_channel;
    logic [7:0]  req_cmd;
    logic [23:0] req_addr;
    logic [9:0]  req_len;
    logic        req_buf;
    logic        abort_in;
    logic        done_valid;
    logic        done_aborted;
    logic        spi_wr_en;
    logic [1:0]  spi_wr_sel;
    logic [9:0]  spi_wr_addr;
    logic [7:0]  spi_wr_data;
    logic        spi_busy = 1'b0;

    always #5 clk = ~clk;

    spi_flash_seq #(
        .StartLatency  (START_LAT),
        .TimeoutCycles (TIMEOUT)
    ) dut (
        .transfer_clk_i (clk),
        .reset_i        (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_channel_i  (req_channel),
        .req_cmd_i      (req_cmd),
        .req_addr_i     (req_addr),
        .req_len_i      (req_len),
        .req_buf_i      (req_buf),
        .abort_i        (abort_in),
        .done_valid_o   (done_valid),
        .done_aborted_o (done_aborted),
        .spi_wr_en_o    (spi_wr_en),
        .spi_wr_sel_o   (spi_wr_sel),
        .spi_wr_addr_o  (spi_wr_addr),
        .spi_wr_data_o  (spi_wr_data),
        .spi_busy_i     (spi_busy)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [9:0]  len;
        logic        bsel;
        logic [7:0]  exp_cnt2;
        logic [7:0]  exp_chi;
        logic [7:0]  exp_dhi;
    } vec_t;

    vec_t vecs[4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_len = 10;
    int busy_cnt = 0;
    bit stuck = 1'b0;

    logic [19:0] log_w[$];
    int          log_cyc[$];
    bit          log_busy[$];
    int          acc_cyc[$];
    int          done_cyc[$];
    bit          done_ab[$];
    logic [19:0] exp_w[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spi_wr_en) begin
            log_w.push_back({spi_wr_sel, spi_wr_addr, spi_wr_data});
            log_cyc.push_back(cyc);
            log_busy.push_back(spi_busy);
        end
        if (req_valid && req_ready && !reset) acc_cyc.push_back(cyc);
        if (done_valid) begin
            done_cyc.push_back(cyc);
            done_ab.push_back(done_aborted);
        end
    end

    // Engine model: busy for busy_len cycles after any start write
    always @(posedge clk) begin
        #1;
        if (busy_cnt > 0) busy_cnt--;
        if (spi_wr_en && spi_wr_sel == 2'd2 && spi_wr_data[7]) busy_cnt = busy_len;
        spi_busy = stuck || (busy_cnt != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        log_w.delete();
        log_cyc.delete();
        log_busy.delete();
        acc_cyc.delete();
        done_cyc.delete();
        done_ab.delete();
        exp_w.delete();
    endtask

    task automatic push_head(input vec_t v, input int n);
        logic [19:0] l[9];
        l[0] = {2'd3, 10'd0, v.exp_cnt2};
        l[1] = {2'd0, 10'd0, v.cmd};
        l[2] = {2'd0, 10'd1, v.addr[23:16]};
        l[3] = {2'd0, 10'd2, v.addr[15:8]};
        l[4] = {2'd0, 10'd3, v.addr[7:0]};
        l[5] = {2'd1, 10'd0, 8'h03};
        l[6] = {2'd2, 10'd0, v.exp_chi};
        l[7] = {2'd1, 10'd0, v.len[7:0]};
        l[8] = {2'd2, 10'd0, v.exp_dhi};
        for (int k = 0; k < n; k++) exp_w.push_back(l[k]);
    endtask

    task automatic push_normal(input vec_t v);
        push_head(v, 9);
        exp_w.push_back({2'd3, 10'd0, 8'h00});
    endtask

    task automatic check_log(input string name);
        int n;
        chk({name, ".nwrites"}, 32'(log_w.size()), 32'(exp_w.size()));
        n = (log_w.size() < exp_w.size()) ? log_w.size() : exp_w.size();
        for (int k = 0; k < n; k++)
            chk($sformatf("%s.w%0d", name, k), 32'(log_w[k]), 32'(exp_w[k]));
    endtask

    task automatic set_req(input vec_t v);
        req_channel = v.ch;
        req_cmd     = v.cmd;
        req_addr    = v.addr;
        req_len     = v.len;
        req_buf     = v.bsel;
    endtask

    task automatic wait_acc(input string name, input int want, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (acc_cyc.size() >= want) got = 1'b1;
        end
        chk({name, ".accepted"}, 32'(got), 32'd1);
    endtask

    task automatic do_req(input string name, input vec_t v);
        set_req(v);
        req_valid = 1'b1;
        wait_acc(name, acc_cyc.size() + 1, 50);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int want, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (done_cyc.size() >= want) got = 1'b1;
        end
        chk({name, ".done_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_writes(input string name, input int want, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (log_w.size() >= want) got = 1'b1;
        end
        chk({name, ".writes_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        int n0;
        vecs[0] = '{2'd2, 8'h03, 24'h123456, 10'h0FF, 1'b0, 8'h04, 8'h80, 8'h90};
        vecs[1] = '{2'd1, 8'h0B, 24'hABCDEF, 10'h3FF, 1'b1, 8'h02, 8'hC0, 8'hD3};
        vecs[2] = '{2'd3, 8'h9F, 24'h000001, 10'h000, 1'b0, 8'h06, 8'h80, 8'h90};
        vecs[3] = '{2'd2, 8'hEB, 24'hFFFFFF, 10'h100, 1'b1, 8'h04, 8'hC0, 8'hD1};

        reset = 1'b1; req_valid = 1'b0; abort_in = 1'b0;
        set_req(vecs[0]);
        repeat (3) tick();
        chk("rst.ready",        32'(req_ready),    32'd1);
        chk("rst.wr_en",        32'(spi_wr_en),    32'd0);
        chk("rst.wr_sel",       32'(spi_wr_sel),   32'd0);
        chk("rst.wr_addr",      32'(spi_wr_addr),  32'd0);
        chk("rst.wr_data",      32'(spi_wr_data),  32'd0);
        chk("rst.done_valid",   32'(done_valid),   32'd0);
        chk("rst.done_aborted", 32'(done_aborted), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            clear_logs();
            busy_len = 10;
            push_normal(vecs[i]);
            do_req(nm, vecs[i]);
            wait_done(nm, 1, 300);
            repeat (3) tick();
            chk({nm, ".ndone"}, 32'(done_cyc.size()), 32'd1);
            if (done_ab.size() > 0) chk({nm, ".aborted"}, 32'(done_ab[0]), 32'd0);
            check_log(nm);
            if (acc_cyc.size() > 0 && log_cyc.size() >= 7)
                for (int k = 0; k < 7; k++)
                    chk($sformatf("%s.t%0d", nm, k), 32'(log_cyc[k] - acc_cyc[0]), 32'(k + 1));
        end

        // Abort while the data transfer is busy
        clear_logs();
        busy_len = 40;
        push_head(vecs[0], 9);
        exp_w.push_back({2'd2, 10'd0, 8'h00});
        exp_w.push_back({2'd3, 10'd0, 8'h00});
        do_req("abrt", vecs[0]);
        wait_writes("abrt", 9, 200);
        repeat (5) tick();
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        wait_done("abrt", 1, 300);
        if (done_ab.size() > 0) chk("abrt.aborted", 32'(done_ab[0]), 32'd1);
        check_log("abrt");
        if (log_w.size() == 11) begin
            chk("abrt.t_abrt", 32'(log_cyc[9] - log_cyc[8]), 32'd7);
            chk("abrt.desel_idle", 32'(log_busy[10]), 32'd0);
        end
        repeat (3) tick();

        // Engine never goes idle: timeout counted from WAIT entry
        clear_logs();
        busy_len = 10;
        stuck = 1'b1;
        push_head(vecs[2], 7);
        exp_w.push_back({2'd2, 10'd0, 8'h00});
        exp_w.push_back({2'd3, 10'd0, 8'h00});
        do_req("tmo", vecs[2]);
        wait_writes("tmo", 8, 300);
        repeat (5) tick();
        stuck = 1'b0;
        wait_done("tmo", 1, 100);
        if (done_ab.size() > 0) chk("tmo.aborted", 32'(done_ab[0]), 32'd1);
        check_log("tmo");
        if (log_w.size() >= 8 && acc_cyc.size() > 0)
            chk("tmo.t_abrt", 32'(log_cyc[7] - acc_cyc[0]), 32'(8 + START_LAT + TIMEOUT));
        repeat (3) tick();

        // Abort before any start write goes straight to deselect
        clear_logs();
        push_head(vecs[3], 3);
        exp_w.push_back({2'd3, 10'd0, 8'h00});
        do_req("early", vecs[3]);
        repeat (2) tick();
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        wait_done("early", 1, 50);
        if (done_ab.size() > 0) chk("early.aborted", 32'(done_ab[0]), 32'd1);
        check_log("early");
        if (log_w.size() == 4 && acc_cyc.size() > 0)
            chk("early.t_desel", 32'(log_cyc[3] - acc_cyc[0]), 32'd4);
        repeat (3) tick();

        // Reset during TX2
        clear_logs();
        do_req("rstmid", vecs[1]);
        repeat (3) tick();
        chk("rstmid.in_tx2", 32'(spi_wr_addr), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid.ready", 32'(req_ready), 32'd1);
        chk("rstmid.wr_en", 32'(spi_wr_en), 32'd0);
        n0 = log_w.size();
        repeat (20) tick();
        chk("rstmid.no_writes", 32'(log_w.size()), 32'(n0));
        chk("rstmid.no_done", 32'(done_cyc.size()), 32'd0);

        // Back-to-back with valid held high
        clear_logs();
        busy_len = 10;
        push_normal(vecs[0]);
        push_normal(vecs[1]);
        set_req(vecs[0]);
        req_valid = 1'b1;
        wait_acc("b2b.first", 1, 50);
        set_req(vecs[1]);
        wait_done("b2b.first", 1, 300);
        wait_acc("b2b.second", 2, 5);
        req_valid = 1'b0;
        wait_done("b2b.second", 2, 300);
        repeat (3) tick();
        if (acc_cyc.size() >= 2 && done_cyc.size() >= 1)
            chk("b2b.t_accept2", 32'(acc_cyc[1] - done_cyc[0]), 32'd1);
        chk("b2b.ndone", 32'(done_cyc.size()), 32'd2);
        if (done_ab.size() >= 2) begin
            chk("b2b.aborted0", 32'(done_ab[0]), 32'd0);
            chk("b2b.aborted1", 32'(done_ab[1]), 32'd0);
        end
        check_log("b2b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
